// File: rtl/dbg_bus_master.sv
// Debug-side master for the arilla bus: stalls rv_core, takes the bus for one
// word access on behalf of the debug transport and returns a single response.
module dbg_bus_master #(
  parameter int ReadLatency  = 1,
  parameter int DrainTimeout = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic        core_busy,
  output logic        available,
  output logic        intercept,
  output logic [31:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  // state   | meaning
  // IDLE    | waiting for a debug command, core owns the bus
  // DRAIN   | core stalled, waiting for its in-flight transaction to finish
  // ISSUE   | bus taken, one-cycle read/write strobe
  // WAIT    | bus taken, waiting ReadLatency cycles for read data
  // RESP    | response held until the transport takes it
  // RELEASE | core released, back to IDLE next cycle
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_RELEASE
  } state_t;

  localparam logic [7:0] DRAIN_TC = 8'(DrainTimeout);
  localparam logic [3:0] LAT_TC   = 4'(ReadLatency);

  state_t      state, state_nxt;

  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        err_q, err_nxt;
  logic        misalign_q, misalign_nxt;
  logic        accept;
  logic [7:0]  drain_cnt, drain_cnt_nxt;
  logic [3:0]  lat_cnt, lat_cnt_nxt;
  logic [31:0] rdata_nxt;

  logic        cmd_ready_nxt;
  logic        rsp_valid_nxt;
  logic        rsp_error_nxt;
  logic        available_nxt;
  logic        intercept_nxt;
  logic        bus_rd_nxt;
  logic        bus_wr_nxt;
  logic [31:0] bus_addr_nxt;
  logic [3:0]  bus_be_nxt;
  logic [31:0] bus_wdata_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
      drain_cnt  <= '0;
      lat_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      err_q      <= err_nxt;
      misalign_q <= misalign_nxt;
      drain_cnt  <= drain_cnt_nxt;
      lat_cnt    <= lat_cnt_nxt;
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        be_q    <= cmd_be;
      end
    end
  end

  // Both timers are down-counters loaded on entry and retired at terminal count 1.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    err_nxt       = err_q;
    misalign_nxt  = misalign_q;
    drain_cnt_nxt = drain_cnt;
    lat_cnt_nxt   = lat_cnt;
    rdata_nxt     = rsp_rdata;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          rdata_nxt = '0;
          if (cmd_addr[1:0] != 2'b00) begin
            state_nxt    = S_RESP;
            err_nxt      = 1'b1;
            misalign_nxt = 1'b1;
          end else begin
            state_nxt     = S_DRAIN;
            err_nxt       = 1'b0;
            misalign_nxt  = 1'b0;
            drain_cnt_nxt = DRAIN_TC;
          end
        end
      end
      S_DRAIN: begin
        if (!core_busy) begin
          state_nxt = S_ISSUE;
        end else begin
          drain_cnt_nxt = drain_cnt - 8'd1;
          if (drain_cnt == 8'd1) begin
            state_nxt = S_RESP;
            err_nxt   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (write_q) begin
          state_nxt = S_RESP;
        end else begin
          state_nxt   = S_WAIT;
          lat_cnt_nxt = LAT_TC;
        end
      end
      S_WAIT: begin
        lat_cnt_nxt = lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) begin
          state_nxt = S_RESP;
          rdata_nxt = bus_rdata;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt    = S_RELEASE;
          rdata_nxt    = '0;
          err_nxt      = 1'b0;
          misalign_nxt = 1'b0;
        end
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the bus side
  // only ever sees flop outputs and the latched command.
  always_comb begin
    cmd_ready_nxt = (state_nxt == S_IDLE);
    rsp_valid_nxt = (state_nxt == S_RESP);
    rsp_error_nxt = (state_nxt == S_RESP) && err_nxt;
    intercept_nxt = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
    available_nxt = !((state_nxt == S_DRAIN) || (state_nxt == S_ISSUE) ||
                      (state_nxt == S_WAIT)  ||
                      ((state_nxt == S_RESP) && !misalign_nxt));
    bus_rd_nxt    = 1'b0;
    bus_wr_nxt    = 1'b0;
    bus_addr_nxt  = '0;
    bus_be_nxt    = '0;
    bus_wdata_nxt = '0;
    if (state_nxt == S_ISSUE) begin
      bus_rd_nxt   = !write_q;
      bus_wr_nxt   = write_q;
      bus_addr_nxt = addr_q;
      bus_be_nxt   = write_q ? be_q : 4'hF;
      if (write_q) begin
        bus_wdata_nxt = wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      available <= 1'b1;
      intercept <= 1'b0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_error <= rsp_error_nxt;
      rsp_rdata <= rdata_nxt;
      available <= available_nxt;
      intercept <= intercept_nxt;
      bus_rd    <= bus_rd_nxt;
      bus_wr    <= bus_wr_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_be    <= bus_be_nxt;
      bus_wdata <= bus_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_dbg_bus_master.sv
// Bench for dbg_bus_master: directed and random commands against a word
// memory model with timing expectations taken from the documented latencies.
module tb_dbg_bus_master;

  localparam int RL    = 2;
  localparam int DT    = 255;
  localparam int LIMIT = 400;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        core_busy;
  logic        available;
  logic        intercept;
  logic [31:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  dbg_bus_master #(.ReadLatency(RL), .DrainTimeout(DT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_be    (cmd_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .core_busy (core_busy),
    .available (available),
    .intercept (intercept),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory slave on the bus; data is only valid exactly RL cycles after bus_rd
  logic [31:0] smem [256];
  logic [31:0] ref_mem [256];
  logic        init_we;
  logic [7:0]  init_idx;
  logic [31:0] init_val;
  int          rd_age = 0;
  logic [31:0] rd_addr;

  always @(posedge clk) begin
    if (init_we) begin
      smem[init_idx] <= init_val;
    end else if (bus_wr) begin
      for (int b = 0; b < 4; b++)
        if (bus_be[b]) smem[bus_addr[9:2]][8*b +: 8] <= bus_wdata[8*b +: 8];
    end
    if (bus_rd) begin
      rd_age  <= 1;
      rd_addr <= bus_addr;
    end else if (rd_age != 0 && rd_age < 1000) begin
      rd_age <= rd_age + 1;
    end
  end

  always_comb bus_rdata = (rd_age == RL) ? smem[rd_addr[9:2]] : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ctl"}, 32'({available, intercept, cmd_ready, rsp_valid, rsp_error,
                              bus_rd, bus_wr, bus_be}), 32'h400);
    check({tag, " bus_addr"}, bus_addr, 32'h0);
    check({tag, " bus_wdata"}, bus_wdata, 32'h0);
    check({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
  endtask

  // One full command from handshake to release, checked against the model.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int busy_cyc, input int rdy_delay, input logic hold_valid);
    logic        mis, tmo, err;
    int          exp_rsp, exp_stb, exp_icpt;
    logic [31:0] exp_rdata;
    logic [7:0]  idx;
    int          n, stb, icpt, avail_bad, proto_bad, rsp_cyc, wcnt;
    logic        seen, hs, done, got_err, stb_wr;
    logic [31:0] got_rdata, stb_addr, stb_wdata;
    logic [3:0]  stb_be;
    logic [2:0]  rel_val;

    idx      = addr[9:2];
    mis      = (addr[1:0] != 2'b00);
    tmo      = !mis && (busy_cyc >= DT);
    err      = mis || tmo;
    exp_rsp  = mis ? 1 : (tmo ? DT + 1 : (wr ? 3 + busy_cyc : 3 + busy_cyc + RL));
    exp_stb  = err ? 0 : 1;
    exp_icpt = err ? 0 : (wr ? 1 : 1 + RL);
    exp_rdata = (err || wr) ? 32'h0 : ref_mem[idx];
    if (!err && wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];

    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'h1);

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_be    = be;
    core_busy = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = hold_valid;
    cmd_write = ~wr;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_be    = 4'($urandom);

    stb = 0; icpt = 0; avail_bad = 0; proto_bad = 0; rsp_cyc = -1; wcnt = 0;
    seen = 0; hs = 0; done = 0; got_err = 0; got_rdata = 0; stb_wr = 0;
    stb_addr = 0; stb_wdata = 0; stb_be = 0; rel_val = 0;
    for (int i = 1; i <= LIMIT; i++) begin
      @(negedge clk);
      if (hs) begin
        rel_val   = {available, rsp_valid, intercept | cmd_ready};
        done      = 1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        core_busy = 1'b0;
        break;
      end
      if (bus_rd || bus_wr) begin
        stb++;
        stb_wr    = bus_wr;
        stb_addr  = bus_addr;
        stb_be    = bus_be;
        stb_wdata = bus_wdata;
      end
      if (bus_rd && bus_wr) proto_bad++;
      if ((bus_rd || bus_wr) && !intercept) proto_bad++;
      if (intercept) icpt++;
      if (available != mis) avail_bad++;
      if (cmd_ready) proto_bad++;
      if (rsp_valid) begin
        if (!seen) begin
          seen      = 1;
          rsp_cyc   = i;
          got_err   = rsp_error;
          got_rdata = rsp_rdata;
        end else if (rsp_error != got_err || rsp_rdata != got_rdata) begin
          proto_bad++;
        end
        if (wcnt >= rdy_delay) begin
          rsp_ready = 1'b1;
          hs        = 1;
        end
        wcnt++;
      end else if (seen) begin
        proto_bad++;
      end
      core_busy = (i <= busy_cyc);
    end
    if (!done) begin
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      core_busy = 1'b0;
    end

    check({tag, " finished"}, 32'(done), 32'h1);
    check({tag, " rsp_cycle"}, 32'(rsp_cyc), 32'(exp_rsp));
    check({tag, " rsp_error"}, 32'(got_err), 32'(err));
    check({tag, " rsp_rdata"}, got_rdata, exp_rdata);
    check({tag, " strobes"}, 32'(stb), 32'(exp_stb));
    check({tag, " intercept_cycles"}, 32'(icpt), 32'(exp_icpt));
    check({tag, " available"}, 32'(avail_bad), 32'h0);
    check({tag, " protocol"}, 32'(proto_bad), 32'h0);
    check({tag, " release"}, 32'(rel_val), 32'h4);
    if (!err) begin
      check({tag, " strobe_kind"}, 32'(stb_wr), 32'(wr));
      check({tag, " bus_addr"}, stb_addr, addr);
      check({tag, " bus_be"}, 32'(stb_be), wr ? 32'(be) : 32'hF);
      if (wr) check({tag, " bus_wdata"}, stb_wdata, wdata);
    end
  endtask

  initial begin
    logic        found;
    int          bad;
    logic        wr;
    logic [31:0] addr;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_be    = '0;
    rsp_ready = 1'b0;
    core_busy = 1'b0;
    init_we   = 1'b0;
    init_idx  = '0;
    init_val  = '0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      init_we  = 1'b1;
      init_idx = 8'(i);
      init_val = (i == 'h40) ? 32'hDEAD_BEEF : $urandom;
      ref_mem[i] = init_val;
    end
    @(negedge clk);
    init_we = 1'b0;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("rd_100",     1'b0, 32'h100, 32'h0,         4'h0,  0,      0,  1'b0);
    run_txn("wr_104",     1'b1, 32'h104, 32'h1234_5678, 4'h3,  0,      0,  1'b0);
    run_txn("rd_104",     1'b0, 32'h104, 32'h0,         4'h0,  0,      0,  1'b0);
    run_txn("wr_busy5",   1'b1, 32'h200, 32'hA5A5_0F0F, 4'hF,  5,      1,  1'b0);
    run_txn("rd_busy5",   1'b0, 32'h200, 32'h0,         4'h0,  5,      0,  1'b0);
    run_txn("busy300",    1'b0, 32'h108, 32'h0,         4'h0,  300,    0,  1'b0);
    run_txn("busy_dt_m1", 1'b1, 32'h10C, 32'hCAFE_F00D, 4'hC,  DT - 1, 0,  1'b0);
    run_txn("busy_dt",    1'b1, 32'h10C, 32'h0000_0000, 4'hF,  DT,     0,  1'b0);
    run_txn("rd_10c",     1'b0, 32'h10C, 32'h0,         4'h0,  0,      0,  1'b0);
    run_txn("misalign_r", 1'b0, 32'h102, 32'h0,         4'h0,  0,      0,  1'b0);
    run_txn("misalign_w", 1'b1, 32'h103, 32'hFFFF_FFFF, 4'hF,  3,      2,  1'b0);
    run_txn("rdy_wait10", 1'b0, 32'h100, 32'h0,         4'h0,  0,      10, 1'b1);

    for (int t = 0; t < 40; t++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      run_txn($sformatf("rand%0d", t), wr, addr, $urandom, 4'($urandom),
              $urandom_range(0, 6), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // reset asserted while the read is waiting for data
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h100;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (intercept && !bus_rd && !bus_wr) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_reached", 32'(found), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || bus_rd || bus_wr || intercept || !available) bad++;
    end
    check("no_rsp_after_reset", 32'(bad), 32'h0);
    check("idle_after_reset", 32'(cmd_ready), 32'h1);
    rsp_ready = 1'b0;

    run_txn("rd_post_rst", 1'b0, 32'h104, 32'h0, 4'h0, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
